// File: rtl/clk_div_pkg.sv
// Shared constants, types and helpers for the multi-channel clock divider.
package clk_div_pkg;

    localparam int unsigned CLK_DIV_MAX_CHANNELS = 16;
    localparam int unsigned CLK_DIV_MAX_WIDTH    = 64;

    typedef enum logic {
        StIdle,
        StPending
    } cfg_state_e;

    // A zero divisor would stall the channel, so it is treated as 1.
    function automatic logic [CLK_DIV_MAX_WIDTH-1:0] clamp_half(
        input logic [CLK_DIV_MAX_WIDTH-1:0] half
    );
        return (half == '0) ? CLK_DIV_MAX_WIDTH'(1) : half;
    endfunction

    function automatic int unsigned chan_idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: half-period counter, divisor register, divided clock and tick.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] DEFAULT_HALF = WIDTH'(25000)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_sync,
    input  logic             i_load_req,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_loaded,
    output logic             o_clk,
    output logic             o_tick
);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_half;
    logic             r_clk;
    logic             r_tick;
    logic [WIDTH-1:0] w_h;
    logic             w_term;

    assign w_h    = WIDTH'(clamp_half(CLK_DIV_MAX_WIDTH'(r_half)));
    // >= rather than == so a count left beyond a shrunken divisor still wraps.
    assign w_term = i_en && (r_cnt >= (w_h - WIDTH'(1)));

    // A pending divisor lands on the toggle edge, or at once when idle or re-phasing.
    assign o_loaded = i_load_req && (i_sync || !i_en || w_term);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_half <= DEFAULT_HALF;
            r_clk  <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            if (o_loaded) begin
                r_half <= i_load_val;
            end
            if (i_sync) begin
                r_cnt  <= '0;
                r_clk  <= 1'b0;
                r_tick <= 1'b0;
            end else if (w_term) begin
                r_cnt  <= '0;
                r_clk  <= ~r_clk;
                r_tick <= ~r_clk;
            end else if (i_en) begin
                r_cnt  <= r_cnt + WIDTH'(1);
                r_tick <= 1'b0;
            end else begin
                r_tick <= 1'b0;
            end
        end
    end

    assign o_clk  = r_clk;
    assign o_tick = r_tick;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with a single-entry divisor update port.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned      CHANNELS     = 4,
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] DEFAULT_HALF = WIDTH'(25000)
) (
    input  logic                                CLOCK,
    input  logic                                RESET,
    input  logic [CHANNELS-1:0]                 en,
    input  logic                                sync,
    input  logic                                cfg_valid,
    output logic                                cfg_ready,
    input  logic [chan_idx_w(CHANNELS)-1:0]     cfg_chan,
    input  logic [WIDTH-1:0]                    cfg_half,
    output logic [CHANNELS-1:0]                 clk_out,
    output logic [CHANNELS-1:0]                 tick
);

    localparam int unsigned CW = chan_idx_w(CHANNELS);

    cfg_state_e          r_state;
    cfg_state_e          w_state_next;
    logic [WIDTH-1:0]    r_shadow;
    logic [CW-1:0]       r_chan;
    logic                w_accept;
    logic                w_in_range;
    logic                w_pending;
    logic [CHANNELS-1:0] w_load_req;
    logic [CHANNELS-1:0] w_loaded;

    assign w_in_range = (32'(cfg_chan) < CHANNELS);
    assign w_accept   = cfg_valid && cfg_ready;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:    if (w_accept && w_in_range) w_state_next = StPending;
            StPending: if (|w_loaded) w_state_next = StIdle;
            default:   w_state_next = StIdle;
        endcase
    end

    always_comb begin
        cfg_ready = (r_state == StIdle);
        w_pending = (r_state == StPending);
    end

    // Out-of-range channel requests are acknowledged but never captured.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_shadow <= '0;
            r_chan   <= '0;
        end else if (w_accept && w_in_range) begin
            r_shadow <= cfg_half;
            r_chan   <= cfg_chan;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        assign w_load_req[g] = w_pending && (r_chan == CW'(g));

        clk_div_chan #(
            .WIDTH        (WIDTH),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_chan (
            .i_clk      (CLOCK),
            .i_rst      (RESET),
            .i_en       (en[g]),
            .i_sync     (sync),
            .i_load_req (w_load_req[g]),
            .i_load_val (r_shadow),
            .o_loaded   (w_loaded[g]),
            .o_clk      (clk_out[g]),
            .o_tick     (tick[g])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed and randomized checks of clk_div_multi against a behavioural divider model.
module tb_clk_div_multi;
    import clk_div_pkg::*;

    localparam int unsigned CH = 4;
    localparam int unsigned W  = 16;
    localparam logic [W-1:0] DH = W'(4);

    logic          CLOCK;
    logic          RESET;
    logic [CH-1:0] en;
    logic          sync;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_chan;
    logic [W-1:0]  cfg_half;
    logic [CH-1:0] clk_out;
    logic [CH-1:0] tick;

    // Three-channel instance where channel index 3 is out of range.
    logic [2:0]    en3;
    logic          sync3;
    logic          cfg_valid3;
    logic          cfg_ready3;
    logic [1:0]    cfg_chan3;
    logic [W-1:0]  cfg_half3;
    logic [2:0]    clk_out3;
    logic [2:0]    tick3;

    clk_div_multi #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_HALF(DH)) u_dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .en        (en),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_half  (cfg_half),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    clk_div_multi #(.CHANNELS(3), .WIDTH(W), .DEFAULT_HALF(DH)) u_dut3 (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .en        (en3),
        .sync      (sync3),
        .cfg_valid (cfg_valid3),
        .cfg_ready (cfg_ready3),
        .cfg_chan  (cfg_chan3),
        .cfg_half  (cfg_half3),
        .clk_out   (clk_out3),
        .tick      (tick3)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state: per-channel count, level, tick, divisor; one pending update.
    int m_cnt  [CH];
    int m_half [CH];
    bit m_lvl  [CH];
    bit m_tick [CH];
    bit m_pend;
    int m_chan;
    int m_shadow;
    int n3;

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_cnt[i]  = 0;
            m_half[i] = int'(DH);
            m_lvl[i]  = 0;
            m_tick[i] = 0;
        end
        m_pend = 0;
        n3     = 0;
    endtask

    task automatic model_edge();
        bit loaded = 0;
        bit accept = cfg_valid && !m_pend;
        if (RESET) return;
        n3++;
        for (int i = 0; i < CH; i++) begin
            int h    = (m_half[i] == 0) ? 1 : m_half[i];
            bit term = en[i] && (m_cnt[i] >= h - 1);
            if (m_pend && m_chan == i && (sync || !en[i] || term)) begin
                m_half[i] = m_shadow;
                loaded    = 1;
            end
            if (sync) begin
                m_cnt[i]  = 0;
                m_lvl[i]  = 0;
                m_tick[i] = 0;
            end else if (term) begin
                m_cnt[i]  = 0;
                m_lvl[i]  = !m_lvl[i];
                m_tick[i] = m_lvl[i];
            end else begin
                if (en[i]) m_cnt[i]++;
                m_tick[i] = 0;
            end
        end
        if (loaded) begin
            m_pend = 0;
        end else if (accept && int'(cfg_chan) < CH) begin
            m_pend   = 1;
            m_chan   = int'(cfg_chan);
            m_shadow = int'(cfg_half);
        end
    endtask

    task automatic expect_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check(string tag);
        logic [CH-1:0] ec;
        logic [CH-1:0] et;
        bit            l3;
        for (int i = 0; i < CH; i++) begin
            ec[i] = m_lvl[i];
            et[i] = m_tick[i];
        end
        l3 = ((n3 / 4) % 2) == 1;
        expect_eq({tag, ".clk_out"}, 32'(clk_out), 32'(ec));
        expect_eq({tag, ".tick"}, 32'(tick), 32'(et));
        expect_eq({tag, ".cfg_ready"}, 32'(cfg_ready), 32'(!m_pend));
        expect_eq({tag, ".clk_out3"}, 32'(clk_out3), 32'({3{l3}}));
        expect_eq({tag, ".tick3"}, 32'(tick3), 32'({3{l3 && (n3 % 4 == 0) && n3 > 0}}));
        expect_eq({tag, ".cfg_ready3"}, 32'(cfg_ready3), 32'd1);
    endtask

    task automatic step(string tag);
        @(posedge CLOCK);
        model_edge();
        #1;
        check(tag);
    endtask

    task automatic cfg_write(int c, int h);
        int budget = 100;
        while (m_pend && budget > 0) begin
            step("cfg_wait");
            budget--;
        end
        expect_eq("cfg_wait_budget", 32'(budget > 0), 32'd1);
        cfg_valid = 1'b1;
        cfg_chan  = 2'(c);
        cfg_half  = W'(h);
        step("cfg_accept");
        cfg_valid = 1'b0;
    endtask

    initial begin
        RESET      = 1'b1;
        en         = '0;
        sync       = 1'b0;
        cfg_valid  = 1'b0;
        cfg_chan   = '0;
        cfg_half   = '0;
        en3        = 3'b111;
        sync3      = 1'b0;
        cfg_valid3 = 1'b1;
        cfg_chan3  = 2'd3;
        cfg_half3  = W'(1);
        model_reset();

        #12;
        expect_eq("reset.clk_out", 32'(clk_out), 32'd0);
        expect_eq("reset.tick", 32'(tick), 32'd0);
        expect_eq("reset.cfg_ready", 32'(cfg_ready), 32'd1);
        RESET = 1'b0;
        en    = 4'hf;

        // Default divisor 4: rises on edges 4, 12, 20.
        for (int k = 1; k <= 21; k++) begin
            step("t1");
            expect_eq("t1.clk_const", 32'(clk_out), ((k / 4) % 2 == 1) ? 32'hf : 32'h0);
            expect_eq("t1.tick_const", 32'(tick), (k % 8 == 4) ? 32'hf : 32'h0);
        end

        // Counts sit at 1: request ch1 half=2, load lands on edge 24.
        cfg_valid = 1'b1;
        cfg_chan  = 2'd1;
        cfg_half  = W'(2);
        step("t2_accept");
        cfg_valid = 1'b0;
        expect_eq("t2.ready_drop", 32'(cfg_ready), 32'd0);
        step("t2");
        expect_eq("t2.ready_still_low", 32'(cfg_ready), 32'd0);
        step("t2");
        expect_eq("t2.ready_back", 32'(cfg_ready), 32'd1);
        for (int k = 0; k < 16; k++) step("t2_run");

        cfg_write(0, 0);
        for (int k = 0; k < 12; k++) step("t3_half0");

        en[2] = 1'b0;
        for (int k = 0; k < 5; k++) step("t4_hold");
        en[2] = 1'b1;
        for (int k = 0; k < 10; k++) step("t4_resume");

        cfg_write(1, 4);
        cfg_write(3, 3);
        sync = 1'b1;
        step("t5_sync");
        sync = 1'b0;
        expect_eq("t5.clk_cleared", 32'(clk_out), 32'd0);
        expect_eq("t5.ready_back", 32'(cfg_ready), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            step("t5_run");
            expect_eq("t5.h4_pair", 32'(clk_out[2:1]), (k == 4) ? 32'h3 : 32'h0);
        end

        cfg_write(2, 5);
        #2;
        RESET = 1'b1;
        model_reset();
        #1;
        expect_eq("t6.async_clk", 32'(clk_out), 32'd0);
        expect_eq("t6.async_tick", 32'(tick), 32'd0);
        expect_eq("t6.async_ready", 32'(cfg_ready), 32'd1);
        check("t6_async");
        #2;
        RESET = 1'b0;
        en    = 4'hf;
        for (int k = 1; k <= 10; k++) begin
            step("t6_default");
            if (k == 4) expect_eq("t6.default_rise", 32'(clk_out), 32'hf);
        end

        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < CH; i++) en[i] = ($urandom_range(0, 7) != 0);
            sync      = ($urandom_range(0, 31) == 0);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_chan  = 2'($urandom_range(0, 3));
            cfg_half  = W'($urandom_range(0, 6));
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
